// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one partial product per RUN cycle,
// accumulated into a double-width product, with valid/ready on both sides.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);
    localparam int NDIG = (WIDTH + 2) / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     a_sh, acc, pp, acc_sum;
    logic [WIDTH+2:0]  b_sh;   // bit 0 is the implicit B[-1]
    logic [CW-1:0]     cnt;
    logic              accept, last;

    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift instead of indexing by 2i: the current triple is always
    // b_sh[2:0] and a_sh already carries the 2i weighting.
    always_comb begin
        pp = '0;
        case (b_sh[2:0])
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = a_sh << 1;
            3'b100:         pp = -(a_sh << 1);
            3'b101, 3'b110: pp = -a_sh;
            default:        pp = '0;
        endcase
    end

    assign acc_sum = acc + pp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            P    <= '0;
        end else if (accept) begin
            a_sh <= is_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
            b_sh <= {{2{is_signed & B[WIDTH-1]}}, B, 1'b0};
            acc  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            acc  <= acc_sum;
            a_sh <= a_sh << 2;
            b_sh <= b_sh >> 2;
            cnt  <= cnt + CW'(1);
            if (last) P <= acc_sum;
        end
    end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed vector table, backpressure/reset sequences and a random regression
// against a plain multiply reference.
module tb_booth_seq_multiplier;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [W-1:0]   A, B;
    logic [2*W-1:0] P;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .P(P), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      sa, sb;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (s) return 64'(sa * sb);
        return ua * ub;
    endfunction

    // Called and returns at 1 time unit after a rising edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int stall, output logic [63:0] p, output int lat);
        int n = 0;
        A = a; B = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; is_signed = ~s;   // registered operands must not notice
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk("busy_run", busy, 1);
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) chk("done_timeout", 0, 1);
        p = P;
        for (int k = 0; k < stall; k++) begin
            in_valid = (k == 4);          // must be ignored while DONE
            @(posedge clk); #1;
            chk("stall_p", P, p);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b1;                  // not accepted in the handshake cycle
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_p_hold", P, p);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] p, e;
        int lat;
        logic [31:0] ra, rb;
        logic rs;

        vecs[0]  = '{32'd3,        32'd5,        1'b0, 64'h0000_0000_0000_000F};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000_0000_0000_0001};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000_0000_0000_0000};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h0000_0001_FFFF_FFFE};
        vecs[7]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[8]  = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000_0000_0000_0000};
        vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
        vecs[10] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000_0000_8000_0000};
        vecs[11] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000_0001_0000_0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; is_signed = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", P, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, (i == 1) ? 10 : 0, p, lat);
            chk($sformatf("vec%0d_p", i), p, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), lat, 18);
        end

        // Reset in the middle of RUN: everything back to reset values at once.
        A = 32'h12345678; B = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("mid_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_p", P, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(32'd7, 32'd6, 1'b0, 0, p, lat);
        chk("after_rst_p", p, 64'd42);
        chk("after_rst_lat", lat, 18);

        for (int i = 0; i < 2000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            e  = ref_mul(ra, rb, rs);
            do_op(ra, rb, rs, $urandom_range(0, 3), p, lat);
            if (p !== e) chk($sformatf("rand%0d_p", i), p, e);
            else total++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
